// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//   Modulo-MOD up/down counter with a clock-enable prescaler, synchronous
//   clear/load, and free-run or one-shot terminal behaviour. Used as the
//   general timebase / event counter in the block library.
//
// Parameters
//   The count is N bits wide and runs over 0 up to the modulus minus one,
//   with the modulus between 2 and 2**N inclusive. PRESCALE (at least 1)
//   sets how many enabled input cycles make up one count step.
//
// Ports
//   clk           in   clock, all state changes on the rising edge
//   reset         in   asynchronous active-low reset
//   en            in   count enable (gates the prescaler and stepping)
//   up_dn         in   direction, 1 = up, 0 = down, sampled on each step
//   one_shot      in   0 = wrap at terminal, 1 = stop at terminal
//   clear         in   synchronous clear (highest priority)
//   load          in   synchronous load of load_val (saturated to MOD-1)
//   load_val      in   [N-1:0] load value
//   count         out  [N-1:0] current count (registered)
//   complete_tick out  one-cycle pulse per wrap / terminal hit (registered)
//   done          out  sticky one-shot terminal flag (registered)
// -----------------------------------------------------------------------------
module mod_counter #(
  parameter int N        = 4,
  parameter int MOD      = 16,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up_dn,
  input  logic         one_shot,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] count,
  output logic         complete_tick,
  output logic         done
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [N-1:0]  CNT_MAX  = N'(MOD - 1);
  // One extra bit so MOD = 2**N is representable for the load saturation test.
  localparam logic [N:0]    MOD_EXT  = (N + 1)'(MOD);

  logic [PW-1:0] pre_q, pre_d;
  logic [N-1:0]  count_q, count_d;
  logic          tick_q, tick_d;
  logic          done_q, done_d;
  logic          step_s;
  logic          at_term_s;

  // Next-state logic: clear > load > step > hold.
  always_comb begin
    pre_d     = pre_q;
    count_d   = count_q;
    tick_d    = 1'b0;
    done_d    = done_q;
    step_s    = en && (pre_q == PRE_LAST);
    // Terminal value depends on the direction sampled in this cycle.
    at_term_s = up_dn ? (count_q == CNT_MAX) : (count_q == {N{1'b0}});

    if (clear) begin
      pre_d   = {PW{1'b0}};
      count_d = {N{1'b0}};
      done_d  = 1'b0;
    end else if (load) begin
      pre_d   = {PW{1'b0}};
      count_d = ({1'b0, load_val} < MOD_EXT) ? load_val : CNT_MAX;
      done_d  = 1'b0;
    end else begin
      if (en) begin
        pre_d = step_s ? {PW{1'b0}} : (pre_q + PW'(1));
      end else begin
        pre_d = pre_q;
      end

      // Once done is set, steps are ignored until clear/load/reset.
      if (step_s && !done_q) begin
        if (at_term_s) begin
          tick_d = 1'b1;
          if (one_shot) begin
            done_d  = 1'b1;
            count_d = count_q;
          end else begin
            count_d = up_dn ? {N{1'b0}} : CNT_MAX;
          end
        end else begin
          count_d = up_dn ? (count_q + N'(1)) : (count_q - N'(1));
        end
      end else begin
        count_d = count_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q   <= {PW{1'b0}};
      count_q <= {N{1'b0}};
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign count         = count_q;
  assign complete_tick = tick_q;
  assign done          = done_q;

endmodule
